// File: rtl/axi4s_vid_out_timing.sv
// AXI4-Stream to native video output: a free-running raster generates HS/VS/DE,
// and stream frames are locked to the raster on SOF and resynced on framing faults.
module axi4s_vid_out_timing #(
    parameter int DATA_WIDTH = 24,
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 110,
    parameter int H_SYNC     = 40,
    parameter int H_BP       = 220,
    parameter int V_ACTIVE   = 720,
    parameter int V_FP       = 5,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 20,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  S_AXIS_TUSER,
    input  logic                  S_AXIS_TLAST,
    output logic [DATA_WIDTH-1:0] VID_DATA,
    output logic                  VID_DE,
    output logic                  VID_HSYNC,
    output logic                  VID_VSYNC,
    output logic                  LOCKED,
    output logic                  UNDERFLOW,
    output logic                  EOL_ERR
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic [1:0] {S_SEARCH, S_ALIGN, S_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, v_wrap, active, origin, at_eol, hs_i, vs_i;
    logic          ready, accept, show, underflow_d, eol_err_d;

    assign h_wrap = (int'(h_cnt) == H_TOTAL - 1);
    assign v_wrap = (int'(v_cnt) == V_TOTAL - 1);
    assign active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign origin = (h_cnt == '0) && (v_cnt == '0);
    assign at_eol = (int'(h_cnt) == H_ACTIVE - 1);
    assign hs_i   = (int'(h_cnt) >= H_ACTIVE + H_FP) && (int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_i   = (int'(v_cnt) >= V_ACTIVE + V_FP) && (int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign accept = ready && S_AXIS_TVALID;

    // TREADY is held low while in reset even though the state decode says SEARCH.
    assign S_AXIS_TREADY = ready && ARESETN;
    assign LOCKED        = (state_q == S_LOCKED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        show        = 1'b0;
        underflow_d = 1'b0;
        eol_err_d   = 1'b0;
        case (state_q)
            S_SEARCH: begin
                ready = S_AXIS_TVALID && !S_AXIS_TUSER;
                if (S_AXIS_TVALID && S_AXIS_TUSER) state_d = S_ALIGN;
            end
            S_ALIGN: begin
                ready = origin;
                if (origin && S_AXIS_TVALID) begin
                    show    = 1'b1;
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                ready = active && !(S_AXIS_TUSER && !origin);
                show  = 1'b1;
                if (active) begin
                    if (!S_AXIS_TVALID) begin
                        underflow_d = 1'b1;
                        state_d     = S_SEARCH;
                    end else if (S_AXIS_TUSER && !origin) begin
                        eol_err_d = 1'b1;
                        state_d   = S_ALIGN;
                    end else if (S_AXIS_TLAST != at_eol) begin
                        eol_err_d = 1'b1;
                        state_d   = S_SEARCH;
                    end
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_SEARCH;
            VID_DATA  <= '0;
            VID_DE    <= 1'b0;
            VID_HSYNC <= ~HS_POL;
            VID_VSYNC <= ~VS_POL;
            UNDERFLOW <= 1'b0;
            EOL_ERR   <= 1'b0;
        end else begin
            state_q   <= state_d;
            VID_DATA  <= (accept && active) ? S_AXIS_TDATA : '0;
            VID_DE    <= active && show;
            VID_HSYNC <= hs_i ? HS_POL : ~HS_POL;
            VID_VSYNC <= vs_i ? VS_POL : ~VS_POL;
            UNDERFLOW <= underflow_d;
            EOL_ERR   <= eol_err_d;
        end
    end
endmodule

// File: tb/tb_axi4s_vid_out_timing.sv
// Self-checking bench: small raster (8x6), random pixel data, reference model driven by
// cycle position arithmetic and a beat queue standing in for the upstream stream source.
module tb_axi4s_vid_out_timing;
    localparam int DW = 24;
    localparam int HT = 8;
    localparam int FR = 48;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic          S_AXIS_TVALID = 1'b0;
    logic          S_AXIS_TREADY;
    logic          S_AXIS_TUSER = 1'b0;
    logic          S_AXIS_TLAST = 1'b0;
    logic [DW-1:0] VID_DATA;
    logic          VID_DE, VID_HSYNC, VID_VSYNC, LOCKED, UNDERFLOW, EOL_ERR;

    axi4s_vid_out_timing #(
        .DATA_WIDTH(DW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TLAST(S_AXIS_TLAST),
        .VID_DATA(VID_DATA), .VID_DE(VID_DE), .VID_HSYNC(VID_HSYNC), .VID_VSYNC(VID_VSYNC),
        .LOCKED(LOCKED), .UNDERFLOW(UNDERFLOW), .EOL_ERR(EOL_ERR)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t       q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_cyc = 0;
    bit          m_locked = 1'b0;
    bit          m_armed = 1'b0;
    bit          stall = 1'b0;
    logic        exp_ready, obs_ready;
    logic [29:0] exp_out;

    function automatic logic [29:0] obs_out();
        return {VID_DE, VID_HSYNC, VID_VSYNC, LOCKED, UNDERFLOW, EOL_ERR, VID_DATA};
    endfunction

    task automatic push_frame(input int n, input int bad_last, output logic [DW-1:0] first);
        beat_t b;
        first = '0;
        for (int i = 0; i < n; i++) begin
            b.d = DW'($urandom);
            b.u = (i == 0);
            b.l = ((i % 4) == 3) != (i == bad_last);
            q.push_back(b);
            if (i == 0) first = b.d;
        end
    endtask

    // One clock: present the queue head, predict TREADY and the registered outputs, advance.
    task automatic tick();
        int            h, v;
        bit            vld, usr, lst, org, act, rdy, nl, na, uf, ee, de;
        logic [DW-1:0] d;
        h   = m_cyc % HT;
        v   = (m_cyc / HT) % 6;
        vld = (q.size() > 0) && !stall;
        if (vld) begin
            d = q[0].d; usr = q[0].u; lst = q[0].l;
        end else begin
            d = DW'($urandom); usr = 1'b0; lst = 1'b0;
        end
        S_AXIS_TVALID = vld;
        S_AXIS_TDATA  = d;
        S_AXIS_TUSER  = usr;
        S_AXIS_TLAST  = lst;
        org = (h == 0) && (v == 0);
        act = (h < 4) && (v < 3);
        if (m_locked)     rdy = act && !(usr && !org);
        else if (m_armed) rdy = org;
        else              rdy = vld && !usr;
        nl = m_locked; na = m_armed; uf = 1'b0; ee = 1'b0; de = 1'b0;
        if (m_locked) begin
            de = act;
            if (act && !vld) begin
                uf = 1'b1; nl = 1'b0;
            end else if (act && usr && !org) begin
                ee = 1'b1; nl = 1'b0; na = 1'b1;
            end else if (act && (lst != (h == 3))) begin
                ee = 1'b1; nl = 1'b0;
            end
        end else if (m_armed) begin
            if (org && vld) begin
                de = 1'b1; nl = 1'b1; na = 1'b0;
            end
        end else if (vld && usr) begin
            na = 1'b1;
        end
        exp_ready = rdy;
        exp_out   = {de, (h == 5), (v == 4), nl, uf, ee, (rdy && vld && act) ? d : {DW{1'b0}}};
        #1 obs_ready = S_AXIS_TREADY;
        @(posedge ACLK);
        #1;
        if (obs_ready && vld) void'(q.pop_front());
        m_locked = nl;
        m_armed  = na;
        m_cyc++;
    endtask

    task automatic model_reset();
        m_cyc = 0; m_locked = 1'b0; m_armed = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = DW'($urandom);
        repeat (3) @(posedge ACLK);
        #1;
        n_vec += 2;
        if (obs_out() !== 30'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h want %h", obs_out(), 30'd0);
        end
        if (S_AXIS_TREADY !== 1'b0) begin
            n_err++; $display("FAIL reset_tready: got %b want 0", S_AXIS_TREADY);
        end
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        S_AXIS_TVALID = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        int hs_n, vs_n;
        hs_n = 0; vs_n = 0;
        repeat (FR) begin
            tick();
            hs_n += int'(VID_HSYNC);
            vs_n += int'(VID_VSYNC);
            n_vec += 2;
            if (obs_ready !== exp_ready) begin
                n_err++; $display("FAIL idle_tready @%0d: got %b want %b", m_cyc, obs_ready, exp_ready);
            end
            if (obs_out() !== exp_out) begin
                n_err++; $display("FAIL idle_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
            end
        end
        n_vec += 2;
        if (hs_n !== 6) begin
            n_err++; $display("FAIL idle_hs_count: got %0d want 6", hs_n);
        end
        if (vs_n !== 8) begin
            n_err++; $display("FAIL idle_vs_count: got %0d want 8", vs_n);
        end
    endtask

    task automatic test_frame();
        beat_t         b;
        logic [DW-1:0] f1[$];
        logic [DW-1:0] shown[$];
        logic [DW-1:0] first;
        for (int i = 0; i < 3; i++) begin
            b.d = DW'($urandom); b.u = 1'b0; b.l = i[0];
            q.push_back(b);
        end
        push_frame(12, -1, first);
        for (int i = 3; i < q.size(); i++) f1.push_back(q[i].d);
        push_frame(12, -1, first);
        for (int k = 0; k < 2; k++) begin
            repeat (FR) begin
                tick();
                if (k == 1 && VID_DE === 1'b1) shown.push_back(VID_DATA);
                n_vec += 2;
                if (obs_ready !== exp_ready) begin
                    n_err++; $display("FAIL frame_tready @%0d: got %b want %b", m_cyc, obs_ready, exp_ready);
                end
                if (obs_out() !== exp_out) begin
                    n_err++; $display("FAIL frame_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
                end
                if (m_cyc % FR == 0) break;
            end
        end
        n_vec++;
        if (shown.size() !== 12) begin
            n_err++; $display("FAIL frame_de_count: got %0d want 12", shown.size());
        end
        for (int i = 0; i < shown.size() && i < 12; i++) begin
            n_vec++;
            if (shown[i] !== f1[i]) begin
                n_err++; $display("FAIL frame_pixel[%0d]: got %h want %h", i, shown[i], f1[i]);
            end
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] first;
        int            uf_n;
        uf_n = 0;
        push_frame(12, -1, first);
        push_frame(12, -1, first);
        for (int k = 0; k < 2; k++) begin
            repeat (FR) begin
                stall = (k == 0) && (m_cyc % FR >= 10) && (m_cyc % FR <= 12);
                tick();
                uf_n += int'(UNDERFLOW);
                n_vec += 2;
                if (obs_ready !== exp_ready) begin
                    n_err++; $display("FAIL underflow_tready @%0d: got %b want %b", m_cyc, obs_ready, exp_ready);
                end
                if (obs_out() !== exp_out) begin
                    n_err++; $display("FAIL underflow_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
                end
                if (m_cyc % FR == 0) break;
            end
        end
        stall = 1'b0;
        n_vec += 2;
        if (uf_n !== 1) begin
            n_err++; $display("FAIL underflow_pulses: got %0d want 1", uf_n);
        end
        if (LOCKED !== 1'b1) begin
            n_err++; $display("FAIL underflow_relock: got %b want 1", LOCKED);
        end
    endtask

    task automatic test_tlast_err();
        logic [DW-1:0] first;
        int            ee_n;
        ee_n = 0;
        push_frame(12, 2, first);
        push_frame(12, -1, first);
        push_frame(12, -1, first);
        for (int k = 0; k < 3; k++) begin
            repeat (FR) begin
                tick();
                ee_n += int'(EOL_ERR);
                n_vec += 2;
                if (obs_ready !== exp_ready) begin
                    n_err++; $display("FAIL tlast_tready @%0d: got %b want %b", m_cyc, obs_ready, exp_ready);
                end
                if (obs_out() !== exp_out) begin
                    n_err++; $display("FAIL tlast_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
                end
                if (m_cyc % FR == 0) break;
            end
        end
        n_vec += 2;
        if (ee_n !== 1) begin
            n_err++; $display("FAIL tlast_pulses: got %0d want 1", ee_n);
        end
        if (LOCKED !== 1'b1) begin
            n_err++; $display("FAIL tlast_relock: got %b want 1", LOCKED);
        end
    endtask

    task automatic test_tuser_err();
        logic [DW-1:0] first, held;
        int            ee_n;
        bit            seen;
        ee_n = 0;
        seen = 1'b0;
        push_frame(8, -1, first);
        push_frame(12, -1, held);
        push_frame(12, -1, first);
        for (int k = 0; k < 3; k++) begin
            repeat (FR) begin
                tick();
                ee_n += int'(EOL_ERR);
                n_vec += 2;
                if (obs_ready !== exp_ready) begin
                    n_err++; $display("FAIL tuser_tready @%0d: got %b want %b", m_cyc, obs_ready, exp_ready);
                end
                if (obs_out() !== exp_out) begin
                    n_err++; $display("FAIL tuser_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
                end
                if (k == 2 && !seen) begin
                    seen = 1'b1;
                    n_vec++;
                    if ({VID_DE, VID_DATA} !== {1'b1, held}) begin
                        n_err++; $display("FAIL tuser_held_pixel: got %b/%h want 1/%h", VID_DE, VID_DATA, held);
                    end
                end
                if (m_cyc % FR == 0) break;
            end
        end
        n_vec++;
        if (ee_n !== 1) begin
            n_err++; $display("FAIL tuser_pulses: got %0d want 1", ee_n);
        end
    endtask

    task automatic test_async_reset();
        repeat (3) begin
            tick();
            n_vec++;
            if (obs_out() !== exp_out) begin
                n_err++; $display("FAIL areset_pre_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
            end
        end
        #2 ARESETN = 1'b0;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TUSER  = 1'b0;
        #1;
        n_vec += 2;
        if (obs_out() !== 30'd0) begin
            n_err++; $display("FAIL areset_outputs: got %h want %h", obs_out(), 30'd0);
        end
        if (S_AXIS_TREADY !== 1'b0) begin
            n_err++; $display("FAIL areset_tready: got %b want 0", S_AXIS_TREADY);
        end
        @(posedge ACLK);
        #1 ARESETN = 1'b1;
        q.delete();
        model_reset();
        repeat (16) begin
            tick();
            n_vec++;
            if (obs_out() !== exp_out) begin
                n_err++; $display("FAIL areset_post_out @%0d: got %h want %h", m_cyc, obs_out(), exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_underflow();
        test_tlast_err();
        test_tuser_err();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no completion want completion");
        $fatal(1, "watchdog");
    end
endmodule
